apb_slave_regfile: RTL and testbench

//  APB completer (slave) answering the APB master's setup/access cycles.

---
 rtl/apb_slave_regfile_pkg.sv | 16 +
 rtl/apb_slave_regfile_wait_counter.sv | 40 ++++
 rtl/apb_slave_regfile.sv | 150 +++++++++++++++
 tb/tb_apb_slave_regfile.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_regfile_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slave_regfile_pkg;

    typedef enum logic {
        IDLE_S,
        ACCESS_S
    } apb_slave_state_e;

    // Byte-address bits below the word index.
    localparam int unsigned APB_WORD_LSB    = 2;

    // Largest supported wait-state count and the counter width that holds it.
    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned WAIT_CNT_W      = $clog2(WAIT_STATES_MAX + 1) + 1;

endpackage

// File: rtl/apb_slave_regfile_wait_counter.sv
// Access-phase wait counter: loads the wait-state count at setup,
// counts down once per cycle and flags when it reaches zero.
module apb_wait_counter
    import apb_slave_regfile_pkg::*;
#(
    parameter int unsigned CNT_W = WAIT_CNT_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer holding NUM_REGS configuration words, with programmable
// wait states, byte strobes, a read-only status slot and PSLVERR reporting.
module apb_slave_regfile
    import apb_slave_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NBYTES      = DATA_WIDTH / 8,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned RO_IDX      = NUM_REGS - 1
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [NBYTES-1:0]              PSTRB,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned IDX_W = ADDR_WIDTH - APB_WORD_LSB;
    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_slave_state_e      state_q;
    apb_slave_state_e      state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic [NUM_REGS-1:0]   wr_pulse_d;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;

    logic [IDX_W-1:0]      idx;
    logic [SEL_W-1:0]      sel;
    logic                  addr_valid;
    logic                  is_ro;
    logic                  wr_commit;
    logic                  unused_addr_lsb;

    // Word decode; the byte offset bits carry no meaning for word registers.
    assign idx             = PADDR[ADDR_WIDTH-1:APB_WORD_LSB];
    assign sel             = idx[SEL_W-1:0];
    assign addr_valid      = (idx < IDX_W'(NUM_REGS));
    assign is_ro           = (idx == IDX_W'(RO_IDX));
    assign unused_addr_lsb = ^PADDR[APB_WORD_LSB-1:0];

    apb_wait_counter #(
        .CNT_W (WAIT_CNT_W)
    ) u_wait_counter (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .load_i     (cnt_load),
        .load_val_i (WAIT_CNT_W'(WAIT_STATES)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Transfer completes in the access phase once the wait count is exhausted.
    assign PREADY    = (state_q == ACCESS_S) & PSEL & PENABLE & cnt_zero;
    assign PSLVERR   = PREADY & (~addr_valid | (PWRITE & is_ro));
    assign wr_commit = PREADY & PWRITE & addr_valid & ~is_ro;
    assign wr_pulse  = wr_pulse_q;

    // FSM next state and counter control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE_S: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ACCESS_S;
                    cnt_load = 1'b1;
                end
            end
            ACCESS_S: begin
                if (!PSEL) begin
                    state_d = IDLE_S;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (PENABLE) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Read mux: data only for a successful read while PREADY is high.
    always_comb begin
        PRDATA = '0;
        if (PREADY && !PWRITE && addr_valid) begin
            PRDATA = is_ro ? status_in : regs_q[sel];
        end
    end

    // One-hot write pulse for the register written on this edge.
    always_comb begin
        wr_pulse_d = '0;
        if (wr_commit) begin
            wr_pulse_d[sel] = 1'b1;
        end
    end

    // Register bank with per-byte strobes, plus the registered write pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
            if (wr_commit) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (PSTRB[b]) begin
                        regs_q[sel][b*8 +: 8] <= PWDATA[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Flatten the bank for downstream consumers.
    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one instance with one wait state, one with
// none, checked against a word-array model of the register bank.
module tb_apb_slave_regfile;

    localparam int unsigned NR = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         psel     [2];
    logic         penable  [2];
    logic         pwrite   [2];
    logic [3:0]   pstrb    [2];
    logic [31:0]  paddr    [2];
    logic [31:0]  pwdata   [2];
    logic [31:0]  prdata   [2];
    logic         pready   [2];
    logic         pslverr  [2];
    logic [31:0]  status   [2];
    logic [255:0] regs_out [2];
    logic [7:0]   wrp      [2];

    logic [31:0]  mdl [2][NR];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  last_rd;
    logic         last_err;
    logic [7:0]   last_pulse;

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .WAIT_STATES (1)
    ) u_dut_ws1 (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .PSEL      (psel[0]),
        .PENABLE   (penable[0]),
        .PWRITE    (pwrite[0]),
        .PSTRB     (pstrb[0]),
        .PADDR     (paddr[0]),
        .PWDATA    (pwdata[0]),
        .PRDATA    (prdata[0]),
        .PREADY    (pready[0]),
        .PSLVERR   (pslverr[0]),
        .status_in (status[0]),
        .regs_out  (regs_out[0]),
        .wr_pulse  (wrp[0])
    );

    apb_slave_regfile #(
        .WAIT_STATES (0)
    ) u_dut_ws0 (
        .PCLK      (clk),
        .PRESETn   (rst_n),
        .PSEL      (psel[1]),
        .PENABLE   (penable[1]),
        .PWRITE    (pwrite[1]),
        .PSTRB     (pstrb[1]),
        .PADDR     (paddr[1]),
        .PWDATA    (pwdata[1]),
        .PRDATA    (prdata[1]),
        .PREADY    (pready[1]),
        .PSLVERR   (pslverr[1]),
        .status_in (status[1]),
        .regs_out  (regs_out[1]),
        .wr_pulse  (wrp[1])
    );

    function automatic int unsigned ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic logic [255:0] model_flat(input int d);
        logic [255:0] r;
        for (int i = 0; i < NR; i++) r[i*32 +: 32] = mdl[d][i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NR; i++) mdl[d][i] = '0;
    endtask

    // Full APB transfer; starts at #1 after a rising edge and returns at #1
    // after the edge following completion, so calls chain back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        int unsigned idx;
        logic [2:0]  slot;
        bit          ok;
        bit          exp_err;
        bit          done;
        logic [31:0] exp_rd;
        logic [7:0]  exp_pulse;
        int          cyc;

        idx     = addr >> 2;
        slot    = idx[2:0];
        ok      = (idx < NR);
        exp_err = !ok || (wr && idx == NR - 1);
        exp_rd  = '0;
        if (!wr && ok) exp_rd = (idx == NR - 1) ? status[d] : mdl[d][slot];

        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 32) begin
            @(negedge clk);
            cyc++;
            if (pready[d]) begin
                check("rdata", prdata[d], exp_rd);
                check("pslverr", pslverr[d], exp_err);
                last_rd  = prdata[d];
                last_err = pslverr[d];
                done     = 1'b1;
            end else begin
                check("wait_quiet", {pslverr[d], prdata[d]}, '0);
            end
        end
        check("ready_seen", done, 1'b1);
        if (done) check("latency", cyc, ws_of(d) + 1);
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;

        exp_pulse = '0;
        if (done && wr && !exp_err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][slot][b*8 +: 8] = wdata[b*8 +: 8];
            exp_pulse[slot] = 1'b1;
        end
        last_pulse = wrp[d];
        check("wr_pulse", wrp[d], exp_pulse);
        check("regs_out", regs_out[d], model_flat(d));
    endtask

    // Write whose PSEL is withdrawn during the wait cycle (needs WAIT_STATES>=1).
    task automatic abort_write(input int d, input logic [31:0] addr, input logic [31:0] data);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
        paddr[d] = addr; pwdata[d] = data; pstrb[d] = 4'hF;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        @(negedge clk);
        check("abort_wait_ready", pready[d], 1'b0);
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(posedge clk); #1;
        check("abort_pulse", wrp[d], '0);
        check("abort_regs", regs_out[d], model_flat(d));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          d;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            pstrb[i] = '0; paddr[i] = '0; pwdata[i] = '0; status[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            check("rst_pready", pready[i], 1'b0);
            check("rst_prdata", prdata[i], '0);
            check("rst_pslverr", pslverr[i], 1'b0);
            check("rst_regs", regs_out[i], '0);
            check("rst_pulse", wrp[i], '0);
        end
        idle(1);

        // Full-word write, then partial strobes and read-back.
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'b1111);
        check("t2_reg1", regs_out[0][63:32], 32'hDEADBEEF);
        check("t2_pulse", last_pulse, 8'h02);
        check("t2_err", last_err, 1'b0);
        xfer(0, 1'b1, 32'h04, 32'h11223344, 4'b0101);
        check("t3_reg1", regs_out[0][63:32], 32'hDE22BE44);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0);
        check("t3_read", last_rd, 32'hDE22BE44);
        xfer(0, 1'b1, 32'h0C, 32'h55667788, 4'b0000);
        check("zero_strb_pulse", last_pulse, 8'h08);

        // Error cases and the status slot.
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0);
        check("t4_bad_err", last_err, 1'b1);
        check("t4_bad_rd", last_rd, 32'h0);
        xfer(0, 1'b1, 32'h1C, 32'h12345678, 4'hF);
        check("t4_ro_err", last_err, 1'b1);
        check("t4_ro_pulse", last_pulse, 8'h00);
        status[0] = 32'hA5;
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0);
        check("t4_status", last_rd, 32'hA5);

        // Abort followed directly by a normal write.
        abort_write(0, 32'h08, 32'hCAFEF00D);
        check("t5_reg2", regs_out[0][95:64], 32'h0);
        xfer(0, 1'b1, 32'h10, 32'h0BADCAFE, 4'hF);
        check("t5_reg4", regs_out[0][159:128], 32'h0BADCAFE);

        // Access-phase signals without a setup phase must be ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h14; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
        repeat (3) begin
            @(negedge clk);
            check("nosetup_ready", pready[0], 1'b0);
        end
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        check("nosetup_regs", regs_out[0], model_flat(0));
        check("nosetup_pulse", wrp[0], '0);

        // Zero-wait instance: back-to-back writes, then read-back.
        xfer(1, 1'b1, 32'h00, 32'hA1B2C3D4, 4'hF);
        xfer(1, 1'b1, 32'h04, 32'h5E6F7081, 4'hF);
        check("t6_reg0", regs_out[1][31:0], 32'hA1B2C3D4);
        check("t6_reg1", regs_out[1][63:32], 32'h5E6F7081);
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0);
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0);
        check("t6_read1", last_rd, 32'h5E6F7081);

        // Reset in the middle of a wait cycle.
        idle(1);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h08; pwdata[0] = 32'h77777777; pstrb[0] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pready", pready[0], 1'b0);
        check("midrst_prdata", prdata[0], '0);
        check("midrst_regs0", regs_out[0], '0);
        check("midrst_regs1", regs_out[1], '0);
        check("midrst_pulse", wrp[0], '0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        check("postrst_regs", regs_out[0], '0);
        check("postrst_pulse", wrp[0], '0);

        // Randomised traffic on both instances.
        for (int it = 0; it < 160; it++) begin
            d = $urandom_range(0, 1);
            status[d] = $urandom;
            if (d == 0 && $urandom_range(0, 9) == 0) begin
                abort_write(0, $urandom_range(0, 6) << 2, $urandom);
            end else begin
                a = ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
                if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
                xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            end
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
